// File: rtl/mc_core_hs.sv
// Multicycle TSC 16-bit ISA core with a shared req/ack memory port.
// Define MC_CORE_PERF_CNT_EN to add the cycle_count/stall_count performance counters.
module mc_core_hs #(
  parameter int WORD_W = 16,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [WORD_W-1:0] output_port,
  output logic              is_halted,
  output logic [WORD_W-1:0] num_inst
`ifdef MC_CORE_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0] cycle_count,
  output logic [WORD_W-1:0] stall_count
`endif
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [3:0] OP_BNE = 4'd0, OP_BEQ = 4'd1, OP_BGZ = 4'd2, OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4, OP_ORI = 4'd5, OP_LHI = 4'd6, OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8, OP_JMP = 4'd9, OP_JAL = 4'd10, OP_RTYPE = 4'd15;
  localparam logic [5:0] FN_ADD = 6'd0, FN_SUB = 6'd1, FN_AND = 6'd2, FN_ORR = 6'd3;
  localparam logic [5:0] FN_JPR = 6'd25, FN_WWD = 6'd28, FN_HLT = 6'd29;

  state_t state, nextState;

  logic [WORD_W-1:0] pc, regA, regB, aluOut, mdr;
  logic [15:0]       ir;
  logic [WORD_W-1:0] regFile [4];

  logic [3:0]        opcode;
  logic [1:0]        rs, rt, rd;
  logic [5:0]        funct;
  logic [7:0]        imm8;
  logic [WORD_W-1:0] sextImm, zextImm;
  logic              retire;

  assign opcode  = ir[15:12];
  assign rs      = ir[11:10];
  assign rt      = ir[9:8];
  assign rd      = ir[7:6];
  assign funct   = ir[5:0];
  assign imm8    = ir[7:0];
  assign sextImm = {{(WORD_W-8){imm8[7]}}, imm8};
  assign zextImm = WORD_W'(imm8);

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state <= FETCH;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH:  if (mem_ack) nextState = DECODE;
      DECODE: nextState = EXEC;
      EXEC: begin
        nextState = FETCH;
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND || funct == FN_ORR)
              nextState = WB;
            else if (funct == FN_HLT)
              nextState = HALT;
          end
          OP_ADI, OP_ORI, OP_LHI: nextState = WB;
          OP_LWD, OP_SWD:         nextState = MEM;
          default:                nextState = FETCH;
        endcase
      end
      MEM:     if (mem_ack) nextState = (opcode == OP_LWD) ? WB : FETCH;
      WB:      nextState = FETCH;
      HALT:    nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  // The request is gated by reset so an abandoned transaction drops at once.
  always_comb begin
    mem_req   = (state == FETCH || state == MEM) && !reset_n;
    mem_we    = (state == MEM) && (opcode == OP_SWD);
    mem_addr  = (state == MEM) ? aluOut : pc;
    mem_wdata = regB;
    is_halted = (state == HALT);
  end

  assign retire = (state == EXEC || state == MEM || state == WB) && (nextState == FETCH);

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      pc          <= RESET_PC;
      ir          <= '0;
      regA        <= '0;
      regB        <= '0;
      aluOut      <= '0;
      mdr         <= '0;
      output_port <= '0;
      num_inst    <= '0;
      for (int i = 0; i < 4; i++) regFile[i] <= '0;
    end else begin
      if (retire) num_inst <= num_inst + WORD_W'(1);
      case (state)
        FETCH: begin
          if (mem_ack) begin
            ir <= mem_rdata[15:0];
            pc <= pc + WORD_W'(1);
          end
        end
        DECODE: begin
          regA   <= regFile[rs];
          regB   <= regFile[rt];
          aluOut <= pc + sextImm;
        end
        EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              case (funct)
                FN_ADD:  aluOut      <= regA + regB;
                FN_SUB:  aluOut      <= regA - regB;
                FN_AND:  aluOut      <= regA & regB;
                FN_ORR:  aluOut      <= regA | regB;
                FN_JPR:  pc          <= regA;
                FN_WWD:  output_port <= regA;
                default: ;
              endcase
            end
            OP_ADI:         aluOut <= regA + sextImm;
            OP_ORI:         aluOut <= regA | zextImm;
            OP_LHI:         aluOut <= WORD_W'({imm8, 8'h00});
            OP_LWD, OP_SWD: aluOut <= regA + sextImm;
            OP_BNE:         if (regA != regB) pc <= aluOut;
            OP_BEQ:         if (regA == regB) pc <= aluOut;
            OP_BGZ:         if (!regA[WORD_W-1] && regA != '0) pc <= aluOut;
            OP_BLZ:         if (regA[WORD_W-1]) pc <= aluOut;
            OP_JMP:         pc <= {pc[WORD_W-1:12], ir[11:0]};
            OP_JAL: begin
              regFile[2] <= pc;
              pc         <= {pc[WORD_W-1:12], ir[11:0]};
            end
            default: ;
          endcase
        end
        MEM: begin
          if (mem_ack && opcode == OP_LWD) mdr <= mem_rdata;
        end
        WB: begin
          if (opcode == OP_RTYPE)    regFile[rd] <= aluOut;
          else if (opcode == OP_LWD) regFile[rt] <= mdr;
          else                       regFile[rt] <= aluOut;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CORE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      if (state != HALT)       cycle_count <= cycle_count + WORD_W'(1);
      if (mem_req && !mem_ack) stall_count <= stall_count + WORD_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mc_core_hs.sv
// Self-checking bench for mc_core_hs: table-driven programs plus reset and 32-bit sequences.
module tb_mc_core_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        mem_req, mem_we, mem_ack, is_halted;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, output_port, num_inst;
`ifdef MC_CORE_PERF_CNT_EN
  logic [15:0] cycle_count, stall_count;
`endif

  mc_core_hs #(.WORD_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .output_port(output_port), .is_halted(is_halted), .num_inst(num_inst)
`ifdef MC_CORE_PERF_CNT_EN
    , .cycle_count(cycle_count), .stall_count(stall_count)
`endif
  );

  // 32-bit instance with a zero-wait, read-only program memory.
  logic        rst32, req32, we32, ack32, halted32;
  logic [31:0] addr32, wdata32, rdata32, out32, inst32;
  logic [15:0] prog32 [8];
`ifdef MC_CORE_PERF_CNT_EN
  logic [31:0] cyc32, stall32;
`endif

  mc_core_hs #(.WORD_W(32), .RESET_PC(32'h0)) dut32 (
    .clk(clk), .reset_n(rst32),
    .mem_req(req32), .mem_we(we32), .mem_addr(addr32), .mem_wdata(wdata32),
    .mem_rdata(rdata32), .mem_ack(ack32),
    .output_port(out32), .is_halted(halted32), .num_inst(inst32)
`ifdef MC_CORE_PERF_CNT_EN
    , .cycle_count(cyc32), .stall_count(stall32)
`endif
  );

  assign ack32   = req32;
  assign rdata32 = {16'h0000, prog32[addr32[2:0]]};

  // Memory model: program image plus a write overlay, configurable wait states.
  logic [15:0] prog      [256];
  logic [15:0] writeMem  [256];
  logic        writeValid[256];
  int          waitCycles, waitCnt, writeCount, holdErr;
  logic        blockEn, prevWaiting;
  logic [7:0]  blockAddr;
  logic [15:0] prevAddr, lastWAddr, lastWData;

  assign mem_ack   = mem_req && (waitCnt >= waitCycles) && !(blockEn && mem_addr[7:0] == blockAddr);
  assign mem_rdata = writeValid[mem_addr[7:0]] ? writeMem[mem_addr[7:0]] : prog[mem_addr[7:0]];

  always @(posedge clk) begin
    if (reset_n) begin
      waitCnt     <= 0;
      writeCount  <= 0;
      holdErr     <= 0;
      prevWaiting <= 1'b0;
      prevAddr    <= '0;
      lastWAddr   <= '0;
      lastWData   <= '0;
      for (int a = 0; a < 256; a++) writeValid[a] <= 1'b0;
    end else begin
      if (mem_req && !mem_ack) waitCnt <= waitCnt + 1;
      else                     waitCnt <= 0;
      prevWaiting <= mem_req && !mem_ack;
      prevAddr    <= mem_addr;
      if (prevWaiting && mem_req && mem_addr != prevAddr) holdErr <= holdErr + 1;
      if (mem_req && mem_ack && mem_we) begin
        writeMem[mem_addr[7:0]]   <= mem_wdata;
        writeValid[mem_addr[7:0]] <= 1'b1;
        writeCount                <= writeCount + 1;
        lastWAddr                 <= mem_addr;
        lastWData                 <= mem_wdata;
      end
    end
  end

  typedef struct packed {
    logic [0:11][15:0] prog;
    logic [7:0]        hiBase;
    logic [0:1][15:0]  hiProg;
    logic [7:0]        waits;
    logic [15:0]       expOut;
    logic [15:0]       expInst;
    logic [15:0]       expCycles;
    logic [15:0]       expWrites;
    logic [15:0]       expStall;
    logic [15:0]       expWAddr;
    logic [15:0]       expWData;
  } vec_t;

  vec_t vecs [8];
  int   numVecs = 0;
  int   passCount = 0;
  int   checkCount = 0;

  task automatic addVec(input logic [0:11][15:0] p, input logic [7:0] hb, input logic [0:1][15:0] hp,
                        input logic [7:0] w, input logic [15:0] eo, input logic [15:0] ei,
                        input logic [15:0] ec, input logic [15:0] ewr, input logic [15:0] est,
                        input logic [15:0] ewa, input logic [15:0] ewd);
    vecs[numVecs] = {p, hb, hp, w, eo, ei, ec, ewr, est, ewa, ewd};
    numVecs++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic loadProgram(input vec_t v);
    for (int a = 0; a < 256; a++) prog[a] = 16'hF01D;
    for (int i = 0; i < 12; i++) prog[i] = v.prog[i];
    prog[v.hiBase]        = v.hiProg[0];
    prog[v.hiBase + 8'd1] = v.hiProg[1];
    waitCycles = int'(v.waits);
    blockEn    = 1'b0;
  endtask

  task automatic pulseReset();
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, output int cycles, output logic timedOut);
    loadProgram(v);
    pulseReset();
    cycles   = 0;
    timedOut = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (is_halted) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int   cyc;
    logic to;
    logic found;

    reset_n    = 1'b1;
    rst32      = 1'b1;
    waitCycles = 0;
    blockEn    = 1'b0;
    blockAddr  = 8'h20;
    for (int a = 0; a < 256; a++) prog[a] = 16'hF01D;
    prog32 = '{16'h41FF, 16'hF41C, 16'hF580, 16'hF81C, 16'hF01D, 16'hF01D, 16'hF01D, 16'hF01D};

    // LHI/ORI/WWD/HLT, zero-wait and 3-wait memory
    addVec({16'h6012, 16'h5034, 16'hF01C, 16'hF01D, {8{16'hF01D}}}, 8'hF0, {16'hF01D, 16'hF01D},
           8'd0, 16'h1234, 16'd3, 16'd14, 16'd0, 16'd0, 16'h0, 16'h0);
    addVec({16'h6012, 16'h5034, 16'hF01C, 16'hF01D, {8{16'hF01D}}}, 8'hF0, {16'hF01D, 16'hF01D},
           8'd3, 16'h1234, 16'd3, 16'd26, 16'd0, 16'd12, 16'h0, 16'h0);
    // ORI $1 ; SWD $1,0x20($0) ; LWD $3,0x20($0) ; WWD $3 ; HLT
    addVec({16'h51AA, 16'h8120, 16'h7320, 16'hFC1C, 16'hF01D, {7{16'hF01D}}}, 8'hF0, {16'hF01D, 16'hF01D},
           8'd0, 16'h00AA, 16'd4, 16'd19, 16'd1, 16'd0, 16'h0020, 16'h00AA);
    addVec({16'h51AA, 16'h8120, 16'h7320, 16'hFC1C, 16'hF01D, {7{16'hF01D}}}, 8'hF0, {16'hF01D, 16'hF01D},
           8'd2, 16'h00AA, 16'd4, 16'd33, 16'd1, 16'd14, 16'h0020, 16'h00AA);
    // Countdown loop with BNE -2
    addVec({16'h5103, 16'h45FF, 16'h04FE, 16'hF41C, 16'hF01D, {7{16'hF01D}}}, 8'hF0, {16'hF01D, 16'hF01D},
           8'd0, 16'h0000, 16'd8, 16'd31, 16'd0, 16'd0, 16'h0, 16'h0);
    // BEQ skips an LHI
    addVec({16'h1001, 16'h60FF, 16'h5255, 16'hF81C, 16'hF01D, {7{16'hF01D}}}, 8'hF0, {16'hF01D, 16'hF01D},
           8'd0, 16'h0055, 16'd3, 16'd13, 16'd0, 16'd0, 16'h0, 16'h0);
    // BLZ / SUB / BGZ / ORR
    addVec({16'h5105, 16'h42FD, 16'h3801, 16'hF01D, 16'hF6C1, 16'h2C01, 16'hF01D, 16'hFD03,
            16'hF01C, 16'hF01D, 16'hF01D, 16'hF01D}, 8'hF0, {16'hF01D, 16'hF01D},
           8'd0, 16'h000D, 16'd7, 16'd28, 16'd0, 16'd0, 16'h0, 16'h0);
    // JMP 5 ; JAL 0x040 at 5 ; WWD $2, JPR $2 at 0x40 ; HLT at 6
    addVec({16'h9005, {4{16'hF01D}}, 16'hA040, {6{16'hF01D}}}, 8'h40, {16'hF81C, 16'hF819},
           8'd0, 16'h0006, 16'd4, 16'd15, 16'd0, 16'd0, 16'h0, 16'h0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_output_port", output_port, 0);
    checkOutput("rst_is_halted", is_halted, 0);
    checkOutput("rst_num_inst", num_inst, 0);
    checkOutput("rst32_mem_req", req32, 0);
`ifdef MC_CORE_PERF_CNT_EN
    checkOutput("rst_cycle_count", cycle_count, 0);
`endif

    for (int i = 0; i < numVecs; i++) begin
      applyStimulus(vecs[i], cyc, to);
      checkOutput($sformatf("v%0d_halt_timeout", i), to, 0);
      checkOutput($sformatf("v%0d_cycles", i), cyc, vecs[i].expCycles);
      checkOutput($sformatf("v%0d_output_port", i), output_port, vecs[i].expOut);
      checkOutput($sformatf("v%0d_num_inst", i), num_inst, vecs[i].expInst);
      checkOutput($sformatf("v%0d_writes", i), writeCount, vecs[i].expWrites);
      checkOutput($sformatf("v%0d_addr_hold", i), holdErr, 0);
      checkOutput($sformatf("v%0d_halt_req", i), mem_req, 0);
      if (vecs[i].expWrites != 0) begin
        checkOutput($sformatf("v%0d_waddr", i), lastWAddr, vecs[i].expWAddr);
        checkOutput($sformatf("v%0d_wdata", i), lastWData, vecs[i].expWData);
      end
`ifdef MC_CORE_PERF_CNT_EN
      checkOutput($sformatf("v%0d_stall_count", i), stall_count, vecs[i].expStall);
      checkOutput($sformatf("v%0d_cycle_count", i), cycle_count, vecs[i].expCycles);
`endif
    end

    // Reset while the SWD is waiting in MEM
    loadProgram(vecs[2]);
    blockEn = 1'b1;
    pulseReset();
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (mem_req && mem_we) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("mr_store_seen", found, 1);
    checkOutput("mr_addr", mem_addr, 16'h0020);
    checkOutput("mr_wdata", mem_wdata, 16'h00AA);
    checkOutput("mr_num_inst", num_inst, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mr_req_held", mem_req, 1);
    checkOutput("mr_no_write", writeCount, 0);
    #2 reset_n = 1'b1;
    #1;
    checkOutput("mr_req_dropped", mem_req, 0);
    checkOutput("mr_we_dropped", mem_we, 0);
    checkOutput("mr_num_inst_clr", num_inst, 0);
    @(negedge clk);
    reset_n = 1'b0;
    blockEn = 1'b0;
    #1;
    checkOutput("mr_refetch_req", mem_req, 1);
    checkOutput("mr_refetch_addr", mem_addr, 16'h0000);

    // 32-bit datapath: ADI $1,$0,-1 ; WWD $1 ; ADD $2,$1,$1 ; WWD $2 ; HLT
    @(negedge clk);
    rst32 = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    checkOutput("w32_out_before", out32, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("w32_adi", out32, 32'hFFFF_FFFF);
    cyc = 7;
    while (!halted32 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("w32_halted", halted32, 1);
    checkOutput("w32_cycles", cyc, 17);
    checkOutput("w32_add", out32, 32'hFFFF_FFFE);
    checkOutput("w32_num_inst", inst32, 4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
